cdb_arbiter: RTL and testbench

//   Round-robin arbiter for the single common data bus (CDB). Functional units
//   (lw, sw, add, mul, mv) that finish an operation request the bus. One winner
//   per cycle is latched into a registered CDB broadcast (tag + value). The

---
 rtl/cdb_arbiter_pkg.sv | 31 +++
 rtl/cdb_arbiter_rr_pick.sv | 34 +++
 rtl/cdb_arbiter.sv | 150 +++++++++++++++
 tb/tb_cdb_arbiter.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the common-data-bus arbiter.
//   - unit codes (index of each functional unit on the request vector)
//   - bus widths (WORD_SIZE, UNIT_SIZE) and the "no producer" tag
//   - popcount helper used for conflict accounting
package cdb_arbiter_pkg;

  localparam int unsigned WORD_SIZE = 32;
  localparam int unsigned UNIT_SIZE = 8;
  localparam int unsigned NUM_UNITS = 5;

  typedef enum logic [2:0] {
    UNIT_LW  = 3'd0,
    UNIT_SW  = 3'd1,
    UNIT_ADD = 3'd2,
    UNIT_MUL = 3'd3,
    UNIT_MV  = 3'd4
  } unit_e;

  // Tag value meaning "no producer"; never a legal tag on a live request.
  localparam logic [UNIT_SIZE-1:0] TAG_NONE = 8'h7F;

  function automatic int unsigned popcount32(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n += {31'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req_i  : request vector, bit i = unit i
//   ptr_i  : highest-priority index (scan starts here and wraps)
//   gnt_o  : one-hot grant (all zero when nothing requests)
//   idx_o  : binary index of the granted unit
//   any_o  : at least one request present
module cdb_arbiter_rr_pick #(
  parameter int unsigned NUnits = 5,
  parameter int unsigned PtrW   = 3
) (
  input  logic [NUnits-1:0] req_i,
  input  logic [PtrW-1:0]   ptr_i,
  output logic [NUnits-1:0] gnt_o,
  output logic [PtrW-1:0]   idx_o,
  output logic              any_o
);

  always_comb begin : p_pick
    int unsigned j;
    j     = 0;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int unsigned k = 0; k < NUnits; k++) begin
      j = (32'(ptr_i) + k) % NUnits;
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = PtrW'(j);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus (CDB).
// Functional units present finished results; one winner per cycle is latched into a
// registered broadcast (tag + value) consumed by the reservation stations and the
// register-status file.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   req_valid      per-unit result pending
//   req_tag        per-unit producer tag, slice [i*TAG_W +: TAG_W]
//   req_data       per-unit result, slice [i*DATA_W +: DATA_W]
//   req_ready      one-hot combinational grant (transfer on valid & ready)
//   cdb_hold       consumer back-pressure: freeze broadcast and pointer
//   flush          kill broadcast, suppress grants (wins over hold)
//   cdb_valid/tag/data/src  registered broadcast
//   conflict_cnt   saturating count of granting cycles with >1 requester
//   bad_tag        sticky: some live request carried TAG_NONE
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned N_UNITS = NUM_UNITS,
  parameter int unsigned DATA_W  = WORD_SIZE,
  parameter int unsigned TAG_W   = UNIT_SIZE,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_UNITS-1:0]     req_valid,
  input  logic [N_UNITS*TAG_W-1:0]  req_tag,
  input  logic [N_UNITS*DATA_W-1:0] req_data,
  output logic [N_UNITS-1:0]     req_ready,
  input  logic                   cdb_hold,
  input  logic                   flush,
  output logic                   cdb_valid,
  output logic [TAG_W-1:0]       cdb_tag,
  output logic [DATA_W-1:0]      cdb_data,
  output logic [2:0]             cdb_src,
  output logic [CNT_W-1:0]       conflict_cnt,
  output logic                   bad_tag
);

  localparam int unsigned PtrW = 3;
  localparam logic [TAG_W-1:0] TagNone = TAG_W'(TAG_NONE);

  logic [PtrW-1:0]   rr_ptr_q, rr_ptr_d;
  logic              cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
  logic [2:0]        cdb_src_q, cdb_src_d;
  logic [CNT_W-1:0]  conflict_q, conflict_d;
  logic              bad_tag_q, bad_tag_d;

  logic [N_UNITS-1:0] pick_gnt;
  logic [PtrW-1:0]    pick_idx;
  logic               pick_any;
  logic               gate_off;
  logic               grant;
  logic               multi_req;
  logic               tag_none_seen;
  logic [TAG_W-1:0]   win_tag;
  logic [DATA_W-1:0]  win_data;

  cdb_arbiter_rr_pick #(
    .NUnits(N_UNITS),
    .PtrW  (PtrW)
  ) u_rr_pick (
    .req_i(req_valid),
    .ptr_i(rr_ptr_q),
    .gnt_o(pick_gnt),
    .idx_o(pick_idx),
    .any_o(pick_any)
  );

  // Masking ready here is what guarantees no grant coincides with a flush or hold,
  // so no result is dropped.
  assign gate_off  = rst | flush | cdb_hold;
  assign req_ready = gate_off ? '0 : pick_gnt;
  assign grant     = pick_any & ~gate_off;
  assign multi_req = popcount32(32'(req_valid)) > 1;

  // Winner mux and TAG_NONE detection.
  always_comb begin
    win_tag       = '0;
    win_data      = '0;
    tag_none_seen = 1'b0;
    for (int unsigned i = 0; i < N_UNITS; i++) begin
      if (pick_gnt[i]) begin
        win_tag  = win_tag | req_tag[i*TAG_W +: TAG_W];
        win_data = win_data | req_data[i*DATA_W +: DATA_W];
      end
      if (req_valid[i] && (req_tag[i*TAG_W +: TAG_W] == TagNone)) begin
        tag_none_seen = 1'b1;
      end
    end
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    cdb_valid_d = cdb_valid_q;
    cdb_tag_d   = cdb_tag_q;
    cdb_data_d  = cdb_data_q;
    cdb_src_d   = cdb_src_q;
    conflict_d  = conflict_q;
    bad_tag_d   = bad_tag_q | tag_none_seen;

    if (flush) begin
      cdb_valid_d = 1'b0;
      cdb_tag_d   = TagNone;
    end else if (cdb_hold) begin
      // Everything holds.
    end else if (grant) begin
      cdb_valid_d = 1'b1;
      cdb_tag_d   = win_tag;
      cdb_data_d  = win_data;
      cdb_src_d   = 3'(pick_idx);
      rr_ptr_d    = (pick_idx == PtrW'(N_UNITS - 1)) ? '0 : pick_idx + PtrW'(1);
      if (multi_req && (conflict_q != '1)) begin
        conflict_d = conflict_q + CNT_W'(1);
      end
    end else begin
      cdb_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= TagNone;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
      conflict_q  <= '0;
      bad_tag_q   <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
      cdb_src_q   <= cdb_src_d;
      conflict_q  <= conflict_d;
      bad_tag_q   <= bad_tag_d;
    end
  end

  assign cdb_valid    = cdb_valid_q;
  assign cdb_tag      = cdb_tag_q;
  assign cdb_data     = cdb_data_q;
  assign cdb_src      = cdb_src_q;
  assign conflict_cnt = conflict_q;
  assign bad_tag      = bad_tag_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, single request, round-robin order,
// hold, flush and bad-tag behaviour with hand-computed expectations.
module tb_cdb_arbiter;

  localparam int unsigned NU = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned TW = 8;
  localparam int unsigned CW = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [NU-1:0]    req_valid;
  logic [NU*TW-1:0] req_tag;
  logic [NU*DW-1:0] req_data;
  logic [NU-1:0]    req_ready;
  logic             cdb_hold;
  logic             flush;
  logic             cdb_valid;
  logic [TW-1:0]    cdb_tag;
  logic [DW-1:0]    cdb_data;
  logic [2:0]       cdb_src;
  logic [CW-1:0]    conflict_cnt;
  logic             bad_tag;

  int n_cmp = 0;
  int n_bad = 0;

  cdb_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_tag     (req_tag),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .cdb_hold    (cdb_hold),
    .flush       (flush),
    .cdb_valid   (cdb_valid),
    .cdb_tag     (cdb_tag),
    .cdb_data    (cdb_data),
    .cdb_src     (cdb_src),
    .conflict_cnt(conflict_cnt),
    .bad_tag     (bad_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [TW-1:0] t,
                         input logic [DW-1:0] d);
    req_valid[i]         = v;
    req_tag[i*TW +: TW]  = t;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic chk_cdb(input string tag, input logic v, input logic [TW-1:0] t,
                         input logic [DW-1:0] d, input logic [2:0] s);
    chk({tag, ".valid"}, 64'(cdb_valid), 64'(v));
    chk({tag, ".tag"},   64'(cdb_tag),   64'(t));
    chk({tag, ".data"},  64'(cdb_data),  64'(d));
    chk({tag, ".src"},   64'(cdb_src),   64'(s));
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_tag   = '0;
    req_data  = '0;
    cdb_hold  = 1'b0;
    flush     = 1'b0;

    // Reset then idle
    tick();
    chk_cdb("rst1", 1'b0, 8'h7F, 32'd0, 3'd0);
    chk("rst1.cnt", 64'(conflict_cnt), 64'd0);
    chk("rst1.bad", 64'(bad_tag), 64'd0);
    set_req(2, 1'b1, 8'h02, 32'd42);
    #1 chk("rst2.ready", 64'(req_ready), 64'd0);
    tick();
    chk_cdb("rst2", 1'b0, 8'h7F, 32'd0, 3'd0);

    // Single request from unit 2
    rst = 1'b0;
    #1 chk("single.ready", 64'(req_ready), 64'b00100);
    tick();
    chk_cdb("single.t1", 1'b1, 8'h02, 32'd42, 3'd2);
    chk("single.cnt", 64'(conflict_cnt), 64'd0);
    set_req(2, 1'b0, 8'h00, 32'd0);
    tick();
    chk_cdb("single.t2", 1'b0, 8'h02, 32'd42, 3'd2);

    // Round-robin from rr_ptr=0 with all units requesting
    rst = 1'b1;
    for (int i = 0; i < 5; i++) set_req(i, 1'b1, 8'(8'h10 + i), 32'(100 + i));
    tick();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1 chk($sformatf("rr%0d.ready", k), 64'(req_ready), 64'(5'b00001 << (k % 5)));
      tick();
      chk_cdb($sformatf("rr%0d", k), 1'b1, 8'(8'h10 + k % 5), 32'(100 + k % 5), 3'(k % 5));
    end
    chk("rr.cnt", 64'(conflict_cnt), 64'd6);
    // rr_ptr is now 1

    // Hold: grant unit 3 (units 3 and 4 requesting)
    for (int i = 0; i < 5; i++) set_req(i, 1'b0, 8'h00, 32'd0);
    set_req(3, 1'b1, 8'h03, 32'd7);
    set_req(4, 1'b1, 8'h04, 32'd8);
    #1 chk("hold.grant3", 64'(req_ready), 64'b01000);
    tick();
    set_req(3, 1'b0, 8'h00, 32'd0);
    cdb_hold = 1'b1;
    chk_cdb("hold.t1", 1'b1, 8'h03, 32'd7, 3'd3);
    chk("hold.cnt", 64'(conflict_cnt), 64'd7);
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("hold%0d.ready", k), 64'(req_ready), 64'd0);
      tick();
      chk_cdb($sformatf("hold%0d", k), 1'b1, 8'h03, 32'd7, 3'd3);
    end
    cdb_hold = 1'b0;
    #1 chk("hold.release.ready", 64'(req_ready), 64'b10000);
    tick();
    chk_cdb("hold.unit4", 1'b1, 8'h04, 32'd8, 3'd4);
    chk("hold.cnt2", 64'(conflict_cnt), 64'd7);
    // rr_ptr is now 0

    // Flush while broadcasting, unit 1 requesting
    set_req(4, 1'b0, 8'h00, 32'd0);
    set_req(1, 1'b1, 8'h01, 32'd11);
    flush = 1'b1;
    #1 chk("flush.ready", 64'(req_ready), 64'd0);
    tick();
    flush = 1'b0;
    chk_cdb("flush.t1", 1'b0, 8'h7F, 32'd8, 3'd4);
    #1 chk("flush.after.ready", 64'(req_ready), 64'b00010);
    tick();
    chk_cdb("flush.unit1", 1'b1, 8'h01, 32'd11, 3'd1);
    // rr_ptr is now 2

    // Bad tag from unit 0
    set_req(1, 1'b0, 8'h00, 32'd0);
    set_req(0, 1'b1, 8'h7F, 32'd5);
    #1 chk("bad.ready", 64'(req_ready), 64'b00001);
    chk("bad.before", 64'(bad_tag), 64'd0);
    tick();
    chk_cdb("bad.t1", 1'b1, 8'h7F, 32'd5, 3'd0);
    chk("bad.set", 64'(bad_tag), 64'd1);
    set_req(0, 1'b0, 8'h00, 32'd0);
    tick();
    chk("bad.idle.valid", 64'(cdb_valid), 64'd0);
    chk("bad.sticky", 64'(bad_tag), 64'd1);
    tick();
    chk("bad.sticky2", 64'(bad_tag), 64'd1);

    // Reset clears sticky state and counter
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("final.bad", 64'(bad_tag), 64'd0);
    chk("final.cnt", 64'(conflict_cnt), 64'd0);
    chk_cdb("final", 1'b0, 8'h7F, 32'd0, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
